rr_lock_arbiter: RTL and testbench
==================================

# rr_lock_arbiter

Round-robin arbiter with transaction lock for a shared single-owner resource. It grants one of N requesters at a time and holds the grant while that requester keeps its request asserted. A hold limit forces release so no requester is starved. It replaces the fixed 2-requester arbiter in front of the shared datapath and keeps the same registered one-cycle request-to-grant behaviour.

## Interface
Parameters:
- N, default 4: number of requesters, must be at least 2.
- MAX_HOLD, default 16: maximum consecutive grant cycles per ownership; 0 disables the limit.

Ports:
- clk, input, 1: the single clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- request, input, N: level request per requester, held for the whole transaction.
- grant, output, N: one-hot registered grant; all-zero when idle.
- grant_valid, output, 1: OR of grant, registered.
- grant_id, output, $clog2(N): index of the current owner; 0 when idle.
- hold_cnt, output, $clog2(MAX_HOLD+1) (minimum 1): grant cycles used by the current owner; 0 when idle.
- timeout, output, 1: one-cycle pulse marking a forced release.

## Operation
- Reset values:
  - grant=0, grant_valid=0, grant_id=0, hold_cnt=0, timeout=0.
  - Priority pointer ptr=0, so requester 0 has highest priority.
  - State IDLE.
- Selection:
  - Rotating priority: the first set request bit at index ptr, ptr+1, … mod N.
  - After each grant, ptr becomes the winner index + 1 mod N.
- States:
  - IDLE: grant=0. If any request is sampled, grant the winner and go to BUSY. Otherwise stay.
  - BUSY: the owner holds grant while request[owner]=1. hold_cnt is 1 in the first grant cycle and increments each cycle, saturating at MAX_HOLD.
    - Owner drops request, others pending: hand off directly to the winner at the same edge. No zero cycle. Go to BUSY with hold_cnt=1.
    - Owner drops request, nothing pending: go to IDLE.
    - Forced release: hold_cnt==MAX_HOLD and request[owner]=1 at an edge (MAX_HOLD≠0). Assert timeout for the next cycle. Arbitrate among the other requesters only.
      - If another requester wins, hand off directly.
      - Otherwise go to COOL.
  - COOL: grant=0 for exactly one cycle, then behave as IDLE. The former owner may win again.
- Invariants:
  - grant is never multi-hot.
  - grant_id and grant_valid always match grant.
  - Requests for bits other than the owner's never disturb the current grant.
- Reset mid-operation: at the edge where rst=1 is sampled, all outputs and ptr return to reset values, whatever the state.

## Timing
- Request sampled at edge T gives grant visible after edge T: one-cycle latency. There is no combinational path from request to any output.
- Release latency: the owner's request drop sampled at edge T clears or moves grant at edge T.
- Worst-case wait with all N requesting: (N-1)·MAX_HOLD cycles, plus 1 cycle of COOL if one applies.
- timeout is high for exactly one cycle, coincident with the first cycle of the new grant or the COOL cycle.

## Structure
- Shared package arb_pkg holds:
  - The state enum typedef: IDLE, BUSY, COOL.
  - A helper function computing the index width.
- Sub-module rr_pick: a purely combinational rotating-priority selector.
  - Inputs: req[N], ptr, exclude-mask.
  - Outputs: one-hot pick, pick index, any flag.
- rr_lock_arbiter holds the FSM, ptr, the counter, and the output registers.

## Test plan
All scenarios use N=4 and MAX_HOLD=4. Drive inputs 1 time unit after the rising edge; check outputs 1 time unit after the next edge.
- Reset: rst=1 for 2 cycles with request=1111 -> all outputs 0 throughout. First edge after rst=0 -> grant=0001, grant_id=0, hold_cnt=1.
- Single requester: request=0100 held 2 cycles, then 0000 -> grant=0100 for 2 cycles, then 0000. timeout stays 0.
- Round-robin under timeout: request=1111 held -> grant sequence 0001×4, 0010×4, 0100×4, 1000×4, then 0001. No zero cycles between grants. timeout pulses at each switch.
- Direct hand-off: owner 0001, request changes 0001→0110 -> next cycle grant=0010 with no idle gap. Then drop bit 1 -> grant=0100.
- Solo timeout: request=1000 held -> grant=1000 for 4 cycles, then one cycle of 0000 with timeout=1, then grant=1000 again with hold_cnt=1.
- Reset mid-grant: rst=1 for one cycle while grant=0010 and hold_cnt=2 -> next cycle all outputs 0. After release with request=1111 -> grant=0001.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        COOL
    } state_e;

    // Bit width needed to index n items, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority selector: first set, non-excluded request at ptr, ptr+1, ... mod N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   ptr,
    input  logic [N-1:0]              excl,
    output logic [N-1:0]              pick,
    output logic [idx_width(N)-1:0]   pick_idx,
    output logic                      any
);

    localparam int IW = idx_width(N);

    logic [N-1:0] cand;

    // NOTE: every output gets a default before the loop so no path leaves it unassigned and infers a latch.
    always_comb begin
        cand     = req & ~excl;
        pick_idx = '0;
        any      = 1'b0;
        // Walk from the farthest offset down so the nearest candidate to ptr is assigned last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (cand[idx]) begin
                pick_idx = IW'(idx);
                any      = 1'b1;
            end
        end
        pick = any ? (N'(1) << pick_idx) : '0;
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks the grant to its owner while the request is held,
// with a hold limit that forces release so no requester starves.
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N-1:0]                       request,
    output logic [N-1:0]                       grant,
    output logic                               grant_valid,
    output logic [idx_width(N)-1:0]            grant_id,
    output logic [idx_width(MAX_HOLD+1)-1:0]   hold_cnt,
    output logic                               timeout
);

    localparam int IW = idx_width(N);
    localparam int HW = idx_width(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
    // With the limit disabled the counter just saturates at its full range.
    localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            grant_valid_q, grant_valid_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            timeout_q, timeout_d;

    logic            owner_req;
    logic            forced;
    logic [N-1:0]    pick;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    assign owner_req = |(request & grant_q);
    assign forced    = (state_q == BUSY) && owner_req && (MAX_HOLD != 0) && (hold_q == HOLD_LIM);

    // On a forced release the current owner is masked out so another requester gets its turn.
    rr_pick #(.N(N)) u_pick (
        .req      (request),
        .ptr      (ptr_q),
        .excl     (forced ? grant_q : '0),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        hold_d     = hold_q;
        timeout_d  = 1'b0;

        if (state_q == BUSY && owner_req && !forced) begin
            if (hold_q != HOLD_SAT) begin
                hold_d = hold_q + HW'(1);
            end
        end else begin
            // Owner released (or was forced out), or no owner: arbitrate at this same edge.
            timeout_d = forced;
            if (pick_any) begin
                state_d    = BUSY;
                grant_d    = pick;
                grant_id_d = pick_idx;
                hold_d     = HW'(1);
                ptr_d      = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
            end else begin
                state_d    = forced ? COOL : IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                hold_d     = '0;
            end
        end

        grant_valid_d = |grant_d;
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            hold_q        <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            hold_q        <= hold_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign hold_cnt    = hold_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench: stimulus pushes expected outputs from a behavioural model, a monitor pops and compares.
module tb_rr_lock_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 4;
    localparam int IW   = 2;
    localparam int HW   = 3;

    typedef struct {
        logic [N-1:0]  grant;
        logic          valid;
        logic [IW-1:0] id;
        logic [HW-1:0] hold;
        logic          to;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  request;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;
    logic [HW-1:0] hold_cnt;
    logic          timeout;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: owner index (-1 when nobody holds), cycles held, priority pointer.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;

    rr_lock_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
        .clk         (clk),
        .rst         (rst),
        .request     (request),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .hold_cnt    (hold_cnt),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // First requester at ptr, ptr+1, ... mod N that is asking and is not the excluded one.
    function automatic int winner(input logic [N-1:0] req, input int ptr, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (req[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [N-1:0] req, output exp_t e);
        int  w;
        logic to;
        to = 1'b0;
        if (r) begin
            m_owner = -1; m_held = 0; m_ptr = 0;
        end else if (m_owner >= 0 && req[m_owner] && m_held < MAXH) begin
            m_held++;
        end else begin
            if (m_owner >= 0 && req[m_owner]) to = 1'b1;
            w = winner(req, m_ptr, to ? m_owner : -1);
            if (w >= 0) begin
                m_owner = w; m_held = 1; m_ptr = (w + 1) % N;
            end else begin
                m_owner = -1; m_held = 0;
            end
        end
        e.grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
        e.valid = (m_owner >= 0);
        e.id    = (m_owner >= 0) ? IW'(m_owner) : '0;
        e.hold  = HW'(m_held);
        e.to    = to;
    endtask

    task automatic step(input logic r, input logic [N-1:0] req);
        exp_t e;
        rst     = r;
        request = req;
        model_step(r, req, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: the DUT presents registered outputs every cycle; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("grant",       32'(grant),       32'(e.grant));
                check("grant_valid", 32'(grant_valid), 32'(e.valid));
                check("grant_id",    32'(grant_id),    32'(e.id));
                check("hold_cnt",    32'(hold_cnt),    32'(e.hold));
                check("timeout",     32'(timeout),     32'(e.to));
                check("onehot0",     32'($onehot0(grant)), 32'd1);
            end
        end
    end

    initial begin
        logic [N-1:0] cur;
        rst     = 1'b1;
        request = '0;

        // Reset with all requesting, then round-robin under the hold limit.
        repeat (2) step(1'b1, 4'b1111);
        repeat (18) step(1'b0, 4'b1111);
        repeat (2) step(1'b0, 4'b0000);

        // Single requester.
        repeat (2) step(1'b0, 4'b0100);
        repeat (2) step(1'b0, 4'b0000);

        // Direct hand-off chain.
        repeat (2) step(1'b0, 4'b0001);
        step(1'b0, 4'b0110);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0000);

        // Solo timeout with a cool cycle.
        repeat (7) step(1'b0, 4'b1000);
        repeat (2) step(1'b0, 4'b0000);

        // Reset mid-grant, then recovery.
        repeat (2) step(1'b0, 4'b0010);
        step(1'b1, 4'b0010);
        repeat (2) step(1'b0, 4'b1111);

        // Random: mostly-held requests, occasional toggles and resets.
        cur = 4'b0000;
        repeat (400) begin
            if ($urandom_range(3) == 0) cur[$urandom_range(N - 1)] = ~cur[$urandom_range(N - 1)];
            if ($urandom_range(5) == 0) cur = 4'($urandom_range(15));
            step($urandom_range(63) == 0, cur);
        end

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        #3;
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
